// File: rtl/video_capture_pkg.sv
// Shared types and index-width helpers for the video capture block.
package video_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture
    } vc_state_e;

    typedef logic [23:0] rgb_t;

    localparam int unsigned DefaultMaxW = 512;
    localparam int unsigned DefaultMaxH = 512;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DefaultXW = idx_w(DefaultMaxW);
    localparam int unsigned DefaultYW = idx_w(DefaultMaxH);

endpackage

// File: rtl/vc_edge_det.sv
// Pixel-enable qualified register with rise/fall detection against the previous sample.
module vc_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic q_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= 1'b0;
            prev_q <= 1'b0;
        end else if (ce_i) begin
            q_q    <= d_i;
            prev_q <= q_q;
        end
    end

    assign q_o    = q_q;
    assign rise_o = q_q & ~prev_q;
    assign fall_o = ~q_q & prev_q;

endmodule

// File: rtl/video_capture.sv
// Captures whole frames from the pixel stream into framebuffer writes and measures geometry.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int unsigned MAX_W  = 512,
    parameter int unsigned MAX_H  = 512,
    parameter int unsigned HTOT_W = 12,
    localparam int unsigned XW    = idx_w(MAX_W),
    localparam int unsigned YW    = idx_w(MAX_H)
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              ce_pix_i,
    input  logic              capture_en_i,
    input  logic [7:0]        vga_r_i,
    input  logic [7:0]        vga_g_i,
    input  logic [7:0]        vga_b_i,
    input  logic              vga_hs_i,
    input  logic              vga_vs_i,
    input  logic              vga_hb_i,
    input  logic              vga_vb_i,
    output logic              fb_we_o,
    output logic [XW-1:0]     fb_x_o,
    output logic [YW-1:0]     fb_y_o,
    output logic [23:0]       fb_data_o,
    output logic              frame_done_o,
    output logic [15:0]       frame_count_o,
    output logic [XW:0]       active_w_o,
    output logic [YW:0]       active_h_o,
    output logic [HTOT_W-1:0] h_total_o,
    output logic [HTOT_W-1:0] v_total_o,
    output logic              overflow_o,
    output logic              geom_err_o
);

    localparam logic [XW:0]       XLimit = (XW + 1)'(MAX_W);
    localparam logic [YW:0]       YLimit = (YW + 1)'(MAX_H);
    localparam logic [XW:0]       XOne   = {{XW{1'b0}}, 1'b1};
    localparam logic [YW:0]       YOne   = {{YW{1'b0}}, 1'b1};
    localparam logic [HTOT_W-1:0] HOne   = {{(HTOT_W - 1){1'b0}}, 1'b1};

    logic ce_q, cap_en_q;
    rgb_t rgb_q;

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            ce_q     <= 1'b0;
            cap_en_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            ce_q <= ce_pix_i;
            if (ce_pix_i) begin
                cap_en_q <= capture_en_i;
                rgb_q    <= {vga_r_i, vga_g_i, vga_b_i};
            end
        end
    end

    logic hs_lvl, hs_rise, hs_fall, vs_lvl, vs_rise, vs_fall;
    logic hb_lvl, hb_rise, hb_fall, vb_lvl, vb_rise, vb_fall;

    vc_edge_det u_hs (.clk_i(clk_sys_i), .rst_i(reset_i), .ce_i(ce_pix_i), .d_i(vga_hs_i),
                      .q_o(hs_lvl), .rise_o(hs_rise), .fall_o(hs_fall));
    vc_edge_det u_vs (.clk_i(clk_sys_i), .rst_i(reset_i), .ce_i(ce_pix_i), .d_i(vga_vs_i),
                      .q_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));
    vc_edge_det u_hb (.clk_i(clk_sys_i), .rst_i(reset_i), .ce_i(ce_pix_i), .d_i(vga_hb_i),
                      .q_o(hb_lvl), .rise_o(hb_rise), .fall_o(hb_fall));
    vc_edge_det u_vb (.clk_i(clk_sys_i), .rst_i(reset_i), .ce_i(ce_pix_i), .d_i(vga_vb_i),
                      .q_o(vb_lvl), .rise_o(vb_rise), .fall_o(vb_fall));

    logic unused_edges;
    assign unused_edges = ^{hs_lvl, hs_fall, vs_lvl, vs_fall, hb_fall};

    vc_state_e         state_q, state_d;
    logic [XW:0]       x_q, x_d, ref_q, ref_d, active_w_q, active_w_d;
    logic [YW:0]       y_q, y_d, active_h_q, active_h_d;
    logic              ref_vld_q, ref_vld_d, frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [HTOT_W-1:0] hcnt_q, hcnt_d, h_total_q, h_total_d;
    logic [HTOT_W-1:0] vcnt_q, vcnt_d, v_total_q, v_total_d, vinc;
    logic              ovf_q, ovf_d, geom_q, geom_d;

    // The pixel coincident with the starting vb fall already belongs to the new frame.
    logic start_cap, cap_act, pix_act, x_in, y_in;
    assign start_cap = (state_q == StArmed) && vb_fall && cap_en_q;
    assign cap_act   = (state_q == StCapture) || start_cap;
    assign pix_act   = ce_q && cap_act && !hb_lvl && !vb_lvl;
    assign x_in      = x_q < XLimit;
    assign y_in      = y_q < YLimit;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        ref_d         = ref_q;
        ref_vld_d     = ref_vld_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        active_w_d    = active_w_q;
        active_h_d    = active_h_q;
        hcnt_d        = hcnt_q;
        h_total_d     = h_total_q;
        vcnt_d        = vcnt_q;
        v_total_d     = v_total_q;
        vinc          = vcnt_q;
        ovf_d         = ovf_q;
        geom_d        = geom_q;
        if (ce_q) begin
            if (hs_rise) begin
                h_total_d = hcnt_q;
                hcnt_d    = HOne;
            end else if (hcnt_q != '1) begin
                hcnt_d = hcnt_q + HOne;
            end
            if (hs_rise && vcnt_q != '1) vinc = vcnt_q + HOne;
            if (vs_rise) begin
                v_total_d = vinc;
                vcnt_d    = '0;
            end else begin
                vcnt_d = vinc;
            end

            unique case (state_q)
                StIdle:    if (vb_rise) state_d = StArmed;
                StArmed:   if (start_cap) state_d = StCapture;
                StCapture: if (vb_rise) state_d = StArmed;
                default:   state_d = StIdle;
            endcase

            if (cap_act) begin
                if (pix_act) begin
                    if (x_in) x_d = x_q + XOne;
                    if (!x_in || !y_in) ovf_d = 1'b1;
                end
                // Line close runs before frame close so a coincident last line is counted.
                if (hb_rise && x_q != '0) begin
                    if (!ref_vld_q) begin
                        ref_d     = x_q;
                        ref_vld_d = 1'b1;
                    end else if (x_q != ref_q) begin
                        geom_d = 1'b1;
                    end
                    if (y_in) y_d = y_q + YOne;
                    x_d = '0;
                end
                if (vb_rise) begin
                    active_w_d    = ref_vld_d ? ref_d : '0;
                    active_h_d    = y_d;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    ref_vld_d     = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            ref_q         <= '0;
            ref_vld_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            active_w_q    <= '0;
            active_h_q    <= '0;
            hcnt_q        <= '0;
            h_total_q     <= '0;
            vcnt_q        <= '0;
            v_total_q     <= '0;
            ovf_q         <= 1'b0;
            geom_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ref_q         <= ref_d;
            ref_vld_q     <= ref_vld_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            active_w_q    <= active_w_d;
            active_h_q    <= active_h_d;
            hcnt_q        <= hcnt_d;
            h_total_q     <= h_total_d;
            vcnt_q        <= vcnt_d;
            v_total_q     <= v_total_d;
            ovf_q         <= ovf_d;
            geom_q        <= geom_d;
        end
    end

    assign fb_we_o       = pix_act && x_in && y_in;
    assign fb_x_o        = x_q[XW-1:0];
    assign fb_y_o        = y_q[YW-1:0];
    assign fb_data_o     = rgb_q;
    assign frame_done_o  = frame_done_q;
    assign frame_count_o = frame_count_q;
    assign active_w_o    = active_w_q;
    assign active_h_o    = active_h_q;
    assign h_total_o     = h_total_q;
    assign v_total_o     = v_total_q;
    assign overflow_o    = ovf_q;
    assign geom_err_o    = geom_q;

endmodule

// File: tb/tb_video_capture.sv
// Random-timing frame stimulus with a frame-level reference model and queue scoreboard.
module tb_video_capture;

    localparam int MW = 16;
    localparam int MH = 8;
    localparam int HT = 28;
    localparam int VT = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce, cap_en, hs, vs, hb, vb;
    logic [7:0]  r, g, b;
    logic        fb_we, frame_done, overflow, geom_err;
    logic [3:0]  fb_x;
    logic [2:0]  fb_y;
    logic [23:0] fb_data;
    logic [15:0] frame_count;
    logic [4:0]  active_w;
    logic [3:0]  active_h;
    logic [11:0] h_total, v_total;

    video_capture #(.MAX_W(MW), .MAX_H(MH), .HTOT_W(12)) dut (
        .clk_sys_i(clk), .reset_i(reset), .ce_pix_i(ce), .capture_en_i(cap_en),
        .vga_r_i(r), .vga_g_i(g), .vga_b_i(b),
        .vga_hs_i(hs), .vga_vs_i(vs), .vga_hb_i(hb), .vga_vb_i(vb),
        .fb_we_o(fb_we), .fb_x_o(fb_x), .fb_y_o(fb_y), .fb_data_o(fb_data),
        .frame_done_o(frame_done), .frame_count_o(frame_count),
        .active_w_o(active_w), .active_h_o(active_h),
        .h_total_o(h_total), .v_total_o(v_total),
        .overflow_o(overflow), .geom_err_o(geom_err)
    );

    typedef struct { int cyc; int x; int y; logic [23:0] d; } pix_t;
    typedef struct { int w; int h; int fc; bit ovf; bit geom; } frm_t;

    pix_t pq[$];
    frm_t fq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference model state, tracked per line and per frame.
    bit armed, capt, vb_prev, m_ovf, m_geom;
    int my, mref, m_fc;
    int wid[16];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        pix_t p;
        frm_t f;
        if (fb_we === 1'b1) begin
            if (pq.size() == 0) begin
                check("unexpected_fb_we", 64'd1, 64'd0);
            end else begin
                p = pq.pop_front();
                check("pix_latency", cyc, p.cyc);
                check("pix_x", fb_x, p.x);
                check("pix_y", fb_y, p.y);
                check("pix_data", fb_data, p.d);
            end
        end
        if (frame_done === 1'b1) begin
            if (fq.size() == 0) begin
                check("unexpected_frame_done", 64'd1, 64'd0);
            end else begin
                f = fq.pop_front();
                check("active_w", active_w, f.w);
                check("active_h", active_h, f.h);
                check("frame_count", frame_count, f.fc);
                check("overflow", overflow, f.ovf);
                check("geom_err", geom_err, f.geom);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_active_w"}, active_w, 0);
        check({tag, "_active_h"}, active_h, 0);
        check({tag, "_h_total"}, h_total, 0);
        check({tag, "_flags"}, {overflow, geom_err}, 0);
    endtask

    task automatic step(input bit s_hs, input bit s_vs, input bit s_hb, input bit s_vb,
                        input logic [23:0] rgb, output int at);
        @(negedge clk);
        ce = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        {r, g, b} = rgb;
        hs = s_hs; vs = s_vs; hb = s_hb; vb = s_vb;
        ce = 1'b1;
        at = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        reset = 1'b0;
        armed = 0; capt = 0; m_fc = 0; m_ovf = 0; m_geom = 0;
    endtask

    task automatic fill(input int w);
        for (int i = 0; i < 16; i++) wid[i] = w;
    endtask

    // Lines 0..va-1 are active (wid[] pixels each), the rest are vertical blanking.
    task automatic run_frame(input int va, input bit lay_a, input bit cen, input int tog,
                             input int rst_l);
        int n, at, i, w;
        bit vbv, act;
        logic [23:0] rgb;
        frm_t f;
        cap_en = cen;
        for (int l = 0; l < VT; l++) begin
            if (l == tog) cap_en = ~cap_en;
            if (l == rst_l) do_reset();
            vbv = (l >= va);
            n   = vbv ? 0 : wid[l];
            if (vbv && !vb_prev) begin
                if (capt) begin
                    m_fc = (m_fc + 1) % 65536;
                    f = '{w: (mref < 0) ? 0 : mref, h: my, fc: m_fc, ovf: m_ovf, geom: m_geom};
                    fq.push_back(f);
                    capt = 0;
                end
                armed = 1;
            end
            if (!vbv && vb_prev && armed && cap_en) begin
                capt = 1; armed = 0; my = 0; mref = -1;
            end
            vb_prev = vbv;
            for (int h = 0; h < HT; h++) begin
                act = lay_a ? (h >= HT - n) : (h < n);
                rgb = 24'($urandom);
                step(h == HT - 4 || h == HT - 3, l == VT - 3 || l == VT - 2,
                     vbv || !act, vbv, rgb, at);
                if (act && capt) begin
                    i = lay_a ? h - (HT - n) : h;
                    if (i < MW && my < MH) pq.push_back('{cyc: at + 1, x: i, y: my, d: rgb});
                    else m_ovf = 1;
                end
            end
            if (capt && n > 0) begin
                w = (n < MW) ? n : MW;
                if (mref < 0) mref = w;
                else if (w != mref) m_geom = 1;
                if (my < MH) my++;
            end
        end
    endtask

    initial begin
        int va;
        reset = 1'b1; ce = 1'b0; cap_en = 1'b1;
        {r, g, b} = '0; hs = 0; vs = 0; hb = 0; vb = 0;
        armed = 0; capt = 0; vb_prev = 0; m_ovf = 0; m_geom = 0; m_fc = 0; my = 0; mref = -1;
        repeat (3) @(negedge clk);
        check_reset("init");
        reset = 1'b0;

        fill(0);  run_frame(0, 0, 1, -1, -1);   // priming blank frame
        fill(10); run_frame(6, 1, 1, -1, -1);
        fill(12); run_frame(7, 0, 1, -1, -1);
        fill(9);  run_frame(5, 0, 0, 3, -1);    // capture_en raised mid-frame
        fill(11); run_frame(6, 1, 1, -1, -1);
        fill(10); run_frame(7, 0, 1, -1, 3);    // reset mid-capture
        fill(10); run_frame(8, 1, 1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            va = $urandom_range(3, 8);
            fill($urandom_range(1, MW));
            if ($urandom_range(0, 2) == 0) wid[$urandom_range(1, va - 1)] = 0;
            run_frame(va, 1'($urandom_range(0, 1)), 1, -1, -1);
        end
        fill(10); wid[2] = 9; run_frame(6, 0, 1, -1, -1);  // jitter
        fill(10); run_frame(6, 1, 1, -1, -1);
        fill(20); run_frame(5, 0, 1, -1, -1);              // too wide
        fill(8);  run_frame(10, 1, 1, -1, -1);             // too tall
        for (int k = 0; k < 5; k++) begin
            va = $urandom_range(2, 10);
            fill($urandom_range(1, MW + 3));
            run_frame(va, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 1) == 1) ? 2 : -1, -1);
        end

        @(negedge clk);
        ce = 1'b0;
        repeat (10) @(negedge clk);
        check("pix_queue_drained", pq.size(), 0);
        check("frame_queue_drained", fq.size(), 0);
        check("h_total", h_total, HT);
        check("v_total", v_total, VT);
        check("overflow_sticky", overflow, m_ovf);
        check("geom_err_sticky", geom_err, m_geom);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
